// File: rtl/sr_bank_pkg.sv
// -----------------------------------------------------------------------------
// sr_bank_pkg
// Shared types and helpers for the SR flip-flop bank driver.
//   state_t      : controller states (IDLE, DRIVE, HOLD, CHECK, INIT)
//   init_phase_t : sub-phases of the optional power-up clear sequence
//   RETRY_W      : width of the retry counter
//   sr_excite()  : SR excitation for one bit, returns {s, r}
// -----------------------------------------------------------------------------
package sr_bank_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRIVE = 3'd1,
    HOLD  = 3'd2,
    CHECK = 3'd3,
    INIT  = 3'd4
  } state_t;

  // ARM is the first cycle after reset release; the clear pulse is
  // registered out of it so that s/r stay low while rst_n is asserted.
  typedef enum logic [1:0] {
    INIT_ARM    = 2'd0,
    INIT_PULSE  = 2'd1,
    INIT_SETTLE = 2'd2
  } init_phase_t;

  localparam int RETRY_W = 4;

  // SR excitation: set when the bit must rise, reset when it must fall,
  // otherwise leave the latch alone. Any unknown input lands in the default
  // branch, so X/Z on q reads as "no change" and {1,1} is unreachable.
  function automatic logic [1:0] sr_excite(input logic tgt_bit, input logic q_bit);
    case ({tgt_bit, q_bit})
      2'b10:   return 2'b10;
      2'b01:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/sr_excite_vec.sv
// -----------------------------------------------------------------------------
// sr_excite_vec
// Combinational, WIDTH-wide SR excitation: per bit, derive the S/R command
// that moves q toward tgt. S and R are never both high on any bit.
// Ports:
//   tgt [WIDTH-1:0] in   target word
//   q   [WIDTH-1:0] in   current bank state
//   s   [WIDTH-1:0] out  set command
//   r   [WIDTH-1:0] out  reset command
// -----------------------------------------------------------------------------
module sr_excite_vec
  import sr_bank_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] tgt,
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] r
);

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic [1:0] sr_bit;
      assign sr_bit = sr_excite(tgt[gi], q[gi]);
      assign s[gi]  = sr_bit[1];
      assign r[gi]  = sr_bit[0];
    end
  endgenerate

  // The forbidden SR input combination must never leave this block.
  always_comb begin
    assert ((s & r) == '0);
  end

endmodule

// File: rtl/sr_bank_driver.sv
// -----------------------------------------------------------------------------
// sr_bank_driver
// Drives the S/R inputs of a bank of WIDTH SR flip-flops so the bank takes on
// a requested target word: pulse the excitation command, let the bank settle,
// read it back, retry on mismatch up to MAX_RETRY times.
//
// Parameters:
//   WIDTH      number of flip-flops in the bank
//   PULSE_CYC  cycles the S/R command is held (>=1)
//   SETTLE_CYC cycles of S=R=0 before readback (>=1)
//   MAX_RETRY  extra drive attempts after a failed readback (0..15)
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   target word offered
//   req_ready  out  high only in IDLE
//   req_data   in   target word
//   q_fb       in   current Q of the bank
//   s, r       out  set / reset lines to the bank (registered)
//   done       out  one-cycle pulse, bank matches target
//   err        out  one-cycle pulse, retries exhausted
//   busy       out  high in any state other than IDLE
//
// Build option SR_BANK_INIT_CLEAR_EN: when defined, the bank is cleared after
// reset release (r all ones for PULSE_CYC cycles, then SETTLE_CYC cycles of
// S=R=0) before the first request is accepted.
// -----------------------------------------------------------------------------
module sr_bank_driver
  import sr_bank_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int PULSE_CYC  = 1,
  parameter int SETTLE_CYC = 2,
  parameter int MAX_RETRY  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_data,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] r,
  output logic             done,
  output logic             err,
  output logic             busy
);

  localparam int CNT_MAX = (PULSE_CYC > SETTLE_CYC) ? PULSE_CYC : SETTLE_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]   PULSE_LAST  = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0]   SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE     = CNT_W'(1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);
  localparam logic [RETRY_W-1:0] RETRY_ONE   = RETRY_W'(1);

`ifdef SR_BANK_INIT_CLEAR_EN
  localparam state_t RESET_STATE = INIT;
`else
  localparam state_t RESET_STATE = IDLE;
`endif

  state_t             state_reg;
  logic [WIDTH-1:0]   tgt_reg;
  logic [WIDTH-1:0]   s_reg;
  logic [WIDTH-1:0]   r_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [RETRY_W-1:0] retry_reg;
  logic               done_reg;
  logic               err_reg;
`ifdef SR_BANK_INIT_CLEAR_EN
  init_phase_t        init_phase_reg;
`endif

  // The command is needed on the accept edge (target comes straight from
  // req_data) and on the retry edge (target already held in tgt_reg), so a
  // single excitation block serves both through this mux.
  logic [WIDTH-1:0] exc_tgt;
  logic [WIDTH-1:0] exc_s;
  logic [WIDTH-1:0] exc_r;

  assign exc_tgt = (state_reg == IDLE) ? req_data : tgt_reg;

  sr_excite_vec #(
    .WIDTH (WIDTH)
  ) u_excite (
    .tgt (exc_tgt),
    .q   (q_fb),
    .s   (exc_s),
    .r   (exc_r)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= RESET_STATE;
      tgt_reg        <= '0;
      s_reg          <= '0;
      r_reg          <= '0;
      cnt_reg        <= '0;
      retry_reg      <= '0;
      done_reg       <= 1'b0;
      err_reg        <= 1'b0;
`ifdef SR_BANK_INIT_CLEAR_EN
      init_phase_reg <= INIT_ARM;
`endif
    end else begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            tgt_reg   <= req_data;
            s_reg     <= exc_s;
            r_reg     <= exc_r;
            cnt_reg   <= '0;
            retry_reg <= '0;
            state_reg <= DRIVE;
          end
        end

        DRIVE: begin
          if (cnt_reg == PULSE_LAST) begin
            s_reg     <= '0;
            r_reg     <= '0;
            cnt_reg   <= '0;
            state_reg <= HOLD;
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end

        HOLD: begin
          if (cnt_reg == SETTLE_LAST) begin
            cnt_reg   <= '0;
            state_reg <= CHECK;
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end

        CHECK: begin
          if (q_fb == tgt_reg) begin
            done_reg  <= 1'b1;
            state_reg <= IDLE;
          end else if (retry_reg < RETRY_LIMIT) begin
            // Re-excite from the bank state as read back now, so bits that
            // did land are left alone on the retry.
            retry_reg <= retry_reg + RETRY_ONE;
            s_reg     <= exc_s;
            r_reg     <= exc_r;
            cnt_reg   <= '0;
            state_reg <= DRIVE;
          end else begin
            err_reg   <= 1'b1;
            state_reg <= IDLE;
          end
        end

        INIT: begin
`ifdef SR_BANK_INIT_CLEAR_EN
          case (init_phase_reg)
            INIT_ARM: begin
              r_reg          <= '1;
              cnt_reg        <= '0;
              init_phase_reg <= INIT_PULSE;
            end
            INIT_PULSE: begin
              if (cnt_reg == PULSE_LAST) begin
                r_reg          <= '0;
                cnt_reg        <= '0;
                init_phase_reg <= INIT_SETTLE;
              end else begin
                cnt_reg <= cnt_reg + CNT_ONE;
              end
            end
            default: begin
              if (cnt_reg == SETTLE_LAST) begin
                cnt_reg        <= '0;
                init_phase_reg <= INIT_ARM;
                state_reg      <= IDLE;
              end else begin
                cnt_reg <= cnt_reg + CNT_ONE;
              end
            end
          endcase
`else
          state_reg <= IDLE;
`endif
        end

        default: begin
          s_reg     <= '0;
          r_reg     <= '0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign s         = s_reg;
  assign r         = r_reg;
  assign done      = done_reg;
  assign err       = err_reg;
  assign req_ready = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);

endmodule
